// File: rtl/mini_glyph_pkg.sv
// Shared constants and state encoding for the mini glyph loader.
package mini_glyph_pkg;
    localparam int GLYPH_BYTES  = 32;
    localparam int GLYPH_BITS   = 256;
    localparam int ROW_BITS     = 16;
    localparam int GLYPH_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2
    } glyph_state_t;
endpackage

// File: rtl/glyph_byte_packer.sv
// Byte shift register and byte counter: packs a glyph MSB byte first.
module glyph_byte_packer #(
    parameter int BYTES = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [7:0]         i_byte,
    output logic [8*BYTES-1:0] o_word,
    output logic               o_last_byte
);
    localparam int CNT_W = $clog2(BYTES);

    logic [8*BYTES-1:0] r_shreg;
    logic [CNT_W-1:0]   r_byte_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (i_shift) begin
                r_shreg <= {r_shreg[8*BYTES-9:0], i_byte};
            end
            if (i_clear) begin
                r_byte_cnt <= '0;
            end else if (i_shift) begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign o_word      = r_shreg;
    assign o_last_byte = (r_byte_cnt == CNT_W'(BYTES - 1));
endmodule

// File: rtl/mini_glyph_loader.sv
// Streams bytes from the SoC into 256-bit glyph words and writes them to the
// mini character store, one glyph or a run up to the last index.
//
//  state    | meaning
//  ST_IDLE  | waiting for a load command
//  ST_LOAD  | accepting bytes of the current glyph
//  ST_WRITE | one-cycle write of the packed glyph
module mini_glyph_loader #(
    parameter int ADDR_W      = mini_glyph_pkg::GLYPH_ADDR_W,
    parameter int GLYPH_BYTES = mini_glyph_pkg::GLYPH_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_idx,
    input  logic                     cmd_bulk,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     abort,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [8*GLYPH_BYTES-1:0] wr_data,
    output logic                     busy,
    output logic                     done
);
    import mini_glyph_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    glyph_state_t             r_state;
    glyph_state_t             w_state_next;
    logic [ADDR_W-1:0]        r_cur_idx;
    logic                     r_bulk;
    logic [8*GLYPH_BYTES-1:0] r_wr_data;
    logic [8*GLYPH_BYTES-1:0] w_word;
    logic                     w_last_byte;
    logic                     w_cmd_fire;
    logic                     w_in_fire;
    logic                     w_advance;
    logic                     w_more;

    glyph_byte_packer #(
        .BYTES (GLYPH_BYTES)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_cmd_fire | w_advance),
        .i_shift     (w_in_fire),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_last_byte (w_last_byte)
    );

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign in_ready  = (r_state == ST_LOAD) && !rst;
    assign busy      = (r_state != ST_IDLE);
    assign wr_en     = (r_state == ST_WRITE);
    assign wr_addr   = r_cur_idx;
    assign w_in_fire = in_valid && in_ready;
    assign w_more    = r_bulk && (r_cur_idx != LAST_IDX);
    // The shift register is stable during WRITE; outside it the last written word is held.
    assign wr_data   = wr_en ? w_word : r_wr_data;
    assign done      = wr_en && !w_more && !abort;

    always_comb begin
        w_state_next = r_state;
        w_cmd_fire   = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready && !abort) begin
                    w_cmd_fire   = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_in_fire && w_last_byte) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!abort && w_more) begin
                    w_advance    = 1'b1;
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cur_idx <= '0;
            r_bulk    <= 1'b0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cmd_fire) begin
                r_cur_idx <= cmd_idx;
                r_bulk    <= cmd_bulk;
            end else if (w_advance) begin
                r_cur_idx <= r_cur_idx + ADDR_W'(1);
            end
            if (wr_en) begin
                r_wr_data <= w_word;
            end
        end
    end
endmodule

// File: tb/tb_mini_glyph_loader.sv
// Directed self-checking bench for mini_glyph_loader.
module tb_mini_glyph_loader;
    localparam logic [255:0] SEQ_00 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] SEQ_40 = 256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;
    localparam logic [255:0] SEQ_60 = 256'h606162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f;
    localparam logic [255:0] SEQ_80 = 256'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9f;
    localparam logic [255:0] AT_PAT = 256'h0000_07C0_1830_2008_23C8_2448_2448_2448_23F0_2000_1800_07F0_0000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_idx;
    logic         cmd_bulk;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         abort;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [255:0] wr_data;
    logic         busy;
    logic         done;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int fire_cnt = 0;
    int last_fire_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [3:0]   wa_q[$];
    logic [255:0] wd_q[$];
    int           wc_q[$];

    mini_glyph_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_idx   (cmd_idx),
        .cmd_bulk  (cmd_bulk),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            fire_cnt++;
            last_fire_cyc = cyc;
        end
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [3:0] idx, input logic bulk);
        cmd_valid = 1'b1;
        cmd_idx   = idx;
        cmd_bulk  = bulk;
        @(negedge clk);
        check("cmd_ready_at_cmd", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic took;
        took = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !took; k++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk); #1;
        end
        check("byte_accepted", took, 1'b1);
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int n0, d0, f0;
        logic [255:0] pat;

        rst = 1'b1; cmd_valid = 1'b0; cmd_idx = '0; cmd_bulk = 1'b0;
        in_valid = 1'b0; in_data = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 256'd0);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // bytes offered while idle are refused
        f0 = fire_cnt;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("idle_no_consume", fire_cnt - f0, 0);

        // single load
        n0 = wa_q.size(); d0 = done_cnt;
        send_cmd(4'd5, 1'b0);
        send_seq(8'h00, 32);
        @(negedge clk);
        check("single_wr_en", wr_en, 1'b1);
        check("single_wr_addr", wr_addr, 4'd5);
        check("single_wr_data", wr_data, SEQ_00);
        check("single_done", done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("single_cmd_ready_after", cmd_ready, 1'b1);
        check("single_wr_en_drop", wr_en, 1'b0);
        check("single_data_hold", wr_data, SEQ_00);
        repeat (3) @(posedge clk); #1;
        check("single_write_count", wa_q.size() - n0, 1);
        check("single_latency", wc_q[n0], last_fire_cyc + 1);
        check("single_done_count", done_cnt - d0, 1);
        check("single_done_cycle", done_cyc, wc_q[n0]);

        // bulk from 14 to the last index
        n0 = wa_q.size(); d0 = done_cnt;
        send_cmd(4'd14, 1'b1);
        send_seq(8'h40, 64);
        @(negedge clk);
        check("bulk_wr_en2", wr_en, 1'b1);
        check("bulk_addr2", wr_addr, 4'd15);
        check("bulk_data2", wr_data, SEQ_60);
        check("bulk_done2", done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bulk_idle", busy, 1'b0);
        check("bulk_write_count", wa_q.size() - n0, 2);
        check("bulk_addr1", wa_q[n0], 4'd14);
        check("bulk_data1", wd_q[n0], SEQ_40);
        check("bulk_spacing", wc_q[n0+1] - wc_q[n0], 33);
        check("bulk_done_count", done_cnt - d0, 1);
        check("bulk_done_cycle", done_cyc, wc_q[n0+1]);

        // '@' glyph with random valid gaps
        @(posedge clk); #1;
        n0 = wa_q.size(); f0 = fire_cnt;
        pat = AT_PAT;
        send_cmd(4'd10, 1'b0);
        for (int i = 0; i < 32; i++) send_byte(pat[255-8*i -: 8], int'($urandom_range(0, 3)));
        in_valid = 1'b0;
        @(negedge clk);
        check("at_wr_en", wr_en, 1'b1);
        check("at_addr", wr_addr, 4'd10);
        check("at_data", wr_data, AT_PAT);
        check("at_row1", wr_data[239:224], 16'h07C0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(posedge clk); #1;
        in_valid = 1'b0;
        check("at_bytes_consumed", fire_cnt - f0, 32);
        check("at_write_count", wa_q.size() - n0, 1);

        // abort after 10 bytes
        n0 = wa_q.size(); d0 = done_cnt;
        send_cmd(4'd2, 1'b0);
        send_seq(8'h11, 10);
        abort = 1'b1;
        @(negedge clk);
        check("abort10_busy_before", busy, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort10_idle", busy, 1'b0);
        check("abort10_cmd_ready", cmd_ready, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("abort10_no_write", wa_q.size() - n0, 0);
        check("abort10_no_done", done_cnt - d0, 0);

        // abort coinciding with the 32nd byte
        n0 = wa_q.size(); d0 = done_cnt;
        send_cmd(4'd4, 1'b0);
        send_seq(8'h20, 31);
        in_valid = 1'b1; in_data = 8'hEE; abort = 1'b1;
        @(negedge clk);
        check("abort32_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("abort32_wr_en", wr_en, 1'b0);
        check("abort32_idle", busy, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("abort32_no_write", wa_q.size() - n0, 0);
        check("abort32_no_done", done_cnt - d0, 0);

        // abort in the write cycle of a bulk load
        n0 = wa_q.size(); d0 = done_cnt;
        send_cmd(4'd3, 1'b1);
        send_seq(8'h00, 32);
        abort = 1'b1;
        @(negedge clk);
        check("abortwr_wr_en", wr_en, 1'b1);
        check("abortwr_addr", wr_addr, 4'd3);
        check("abortwr_done", done, 1'b0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abortwr_idle", busy, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h77;
        repeat (4) @(posedge clk); #1;
        in_valid = 1'b0;
        check("abortwr_write_count", wa_q.size() - n0, 1);
        check("abortwr_addr_logged", wa_q[n0], 4'd3);
        check("abortwr_no_done", done_cnt - d0, 0);

        // command offered while loading is ignored
        send_cmd(4'd7, 1'b0);
        send_seq(8'hA0, 5);
        cmd_valid = 1'b1; cmd_idx = 4'd9; cmd_bulk = 1'b1;
        @(negedge clk);
        check("busy_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        send_seq(8'hA5, 27);
        @(negedge clk);
        check("busy_wr_addr", wr_addr, 4'd7);
        check("busy_done_single", done, 1'b1);
        @(posedge clk); #1;

        // reset in the middle of a load
        send_cmd(4'd9, 1'b0);
        send_seq(8'h30, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_wr_addr", wr_addr, 4'd0);
        check("midrst_wr_data", wr_data, 256'd0);
        check("midrst_done", done, 1'b0);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_cmd(4'd1, 1'b0);
        send_seq(8'h80, 32);
        @(negedge clk);
        check("postrst_wr_en", wr_en, 1'b1);
        check("postrst_addr", wr_addr, 4'd1);
        check("postrst_data", wr_data, SEQ_80);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
